// File: rtl/cpu_bus_cycle_ctrl.sv
// cpu_bus_cycle_ctrl: 68030 bus-cycle controller. Samples ASn, decodes the
// latched address into block RAM / SDRAM / unmapped, sequences the target
// handshake and answers with DSACKn (port width) or BERRn (unmapped/timeout).
module cpu_bus_cycle_ctrl #(
    parameter logic [7:0]  BRAM_TOP       = 8'h10,
    parameter logic [7:0]  SDRAM_BASE     = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ASn,
    input  logic [31:0] ADR_OUT,
    input  logic        RWn,
    input  logic        BRAM_ACK,
    input  logic        SDRAM_ACK,
    output logic        BRAM_SEL,
    output logic        SDRAM_REQ,
    output logic        SDRAM_WE,
    output logic [1:0]  DSACKn,
    output logic        BERRn,
    output logic [31:0] LAST_ERR_ADR
);

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_TERM
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic          rwn_q, rwn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bram_sel_q, bram_sel_d;
    logic          sdram_req_q, sdram_req_d;
    logic          sdram_we_q, sdram_we_d;
    logic [1:0]    dsackn_q, dsackn_d;
    logic          berrn_q, berrn_d;
    logic [31:0]   last_err_q, last_err_d;

    logic          is_bram;
    logic          is_sdram;
    logic [CW-1:0] cnt_inc;

    // Address decode of the latched cycle address and saturating counter increment.
    always_comb begin
        is_bram  = (adr_q[31:24] == 8'h00) && (adr_q[23:16] < BRAM_TOP);
        is_sdram = (adr_q[31:24] == SDRAM_BASE);
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    // Next-state and registered-output computation for the bus-cycle FSM.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        rwn_d       = rwn_q;
        cnt_d       = cnt_q;
        bram_sel_d  = bram_sel_q;
        sdram_req_d = 1'b0;
        sdram_we_d  = 1'b0;
        dsackn_d    = dsackn_q;
        berrn_d     = berrn_q;
        last_err_d  = last_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (!ASn) begin
                    adr_d   = ADR_OUT;
                    rwn_d   = RWn;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ASn) begin
                    bram_sel_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else if (is_bram) begin
                    bram_sel_d = 1'b1;
                    state_d    = S_WAIT;
                end else if (is_sdram) begin
                    sdram_req_d = 1'b1;
                    sdram_we_d  = ~rwn_q;
                    state_d     = S_WAIT;
                end else begin
                    berrn_d    = 1'b0;
                    last_err_d = adr_q;
                    state_d    = S_TERM;
                end
            end
            S_WAIT: begin
                if (ASn) begin
                    bram_sel_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    // An ack in the timeout cycle takes priority over the error.
                    if (bram_sel_q && BRAM_ACK) begin
                        dsackn_d = 2'b00;
                        state_d  = S_TERM;
                    end else if (!bram_sel_q && SDRAM_ACK) begin
                        dsackn_d = 2'b01;
                        state_d  = S_TERM;
                    end else if (cnt_inc == CNT_MAX) begin
                        berrn_d    = 1'b0;
                        last_err_d = adr_q;
                        state_d    = S_TERM;
                    end
                end
            end
            S_TERM: begin
                if (ASn) begin
                    dsackn_d   = 2'b11;
                    berrn_d    = 1'b1;
                    bram_sel_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            rwn_q       <= 1'b1;
            cnt_q       <= '0;
            bram_sel_q  <= 1'b0;
            sdram_req_q <= 1'b0;
            sdram_we_q  <= 1'b0;
            dsackn_q    <= 2'b11;
            berrn_q     <= 1'b1;
            last_err_q  <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            rwn_q       <= rwn_d;
            cnt_q       <= cnt_d;
            bram_sel_q  <= bram_sel_d;
            sdram_req_q <= sdram_req_d;
            sdram_we_q  <= sdram_we_d;
            dsackn_q    <= dsackn_d;
            berrn_q     <= berrn_d;
            last_err_q  <= last_err_d;
        end
    end

    assign BRAM_SEL     = bram_sel_q;
    assign SDRAM_REQ    = sdram_req_q;
    assign SDRAM_WE     = sdram_we_q;
    assign DSACKn       = dsackn_q;
    assign BERRn        = berrn_q;
    assign LAST_ERR_ADR = last_err_q;

endmodule

// File: tb/tb_cpu_bus_cycle_ctrl.sv
// Bench for cpu_bus_cycle_ctrl: directed bus cycles; each expected output
// snapshot (with the edge it must appear after) is queued by the stimulus and
// checked by a monitor whenever the DUT's output bundle changes.
module tb_cpu_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ASn;
    logic [31:0] ADR_OUT;
    logic        RWn;
    logic        BRAM_ACK;
    logic        SDRAM_ACK;
    logic        BRAM_SEL;
    logic        SDRAM_REQ;
    logic        SDRAM_WE;
    logic [1:0]  DSACKn;
    logic        BERRn;
    logic [31:0] LAST_ERR_ADR;

    cpu_bus_cycle_ctrl #(
        .BRAM_TOP       (8'h10),
        .SDRAM_BASE     (8'h01),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ASn          (ASn),
        .ADR_OUT      (ADR_OUT),
        .RWn          (RWn),
        .BRAM_ACK     (BRAM_ACK),
        .SDRAM_ACK    (SDRAM_ACK),
        .BRAM_SEL     (BRAM_SEL),
        .SDRAM_REQ    (SDRAM_REQ),
        .SDRAM_WE     (SDRAM_WE),
        .DSACKn       (DSACKn),
        .BERRn        (BERRn),
        .LAST_ERR_ADR (LAST_ERR_ADR)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int          stamp;   // -1: any edge
        logic [37:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event ev_async;

    function automatic logic [37:0] snap(input logic bs, input logic rq, input logic we,
                                         input logic [1:0] ds, input logic be,
                                         input logic [31:0] le);
        return {bs, rq, we, ds, be, le};
    endfunction

    task automatic exp_push(input int stamp, input string name, input logic [37:0] v);
        exp_t e;
        e.stamp = stamp;
        e.val   = v;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: the next posedge samples ASn=0.
    task automatic start(input logic [31:0] a, input logic rw, output int e0);
        ADR_OUT = a;
        RWn     = rw;
        ASn     = 1'b0;
        e0      = edge_no + 1;
    endtask

    // Returns at the negedge following posedge number 'target'.
    task automatic wait_edge(input int target);
        while (edge_no < target) @(negedge clk);
    endtask

    // Monitor: compare every change of the output bundle against the queue head.
    logic [37:0] prev = 'x;
    always begin
        logic [37:0] cur;
        exp_t        e;
        @(negedge clk or ev_async);
        cur = {BRAM_SEL, SDRAM_REQ, SDRAM_WE, DSACKn, BERRn, LAST_ERR_ADR};
        if (cur !== prev) begin
            prev = cur;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change @edge %0d: got %h, none expected", edge_no, cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.val || (e.stamp >= 0 && e.stamp != edge_no))
                begin
                    n_fail++;
                    $display("FAIL %s: got %h @edge %0d, want %h @edge %0d",
                             e.name, cur, edge_no, e.val, e.stamp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset_n   = 1'b0;
        ASn       = 1'b1;
        ADR_OUT   = '0;
        RWn       = 1'b1;
        BRAM_ACK  = 1'b0;
        SDRAM_ACK = 1'b0;
        exp_push(-1, "reset_state", snap(0, 0, 0, 2'b11, 1, 32'h0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Block RAM read, ack sampled at edge 3.
        start(32'h0000_1000, 1'b1, e0);
        exp_push(e0 + 1, "bram_sel",     snap(1, 0, 0, 2'b11, 1, 32'h0));
        exp_push(e0 + 3, "bram_dsack",   snap(1, 0, 0, 2'b00, 1, 32'h0));
        exp_push(e0 + 4, "bram_release", snap(0, 0, 0, 2'b11, 1, 32'h0));
        wait_edge(e0 + 2); BRAM_ACK = 1'b1;
        wait_edge(e0 + 3); BRAM_ACK = 1'b0; ASn = 1'b1;
        wait_edge(e0 + 4);

        // SDRAM write; a stray BRAM_ACK must be ignored.
        start(32'h0100_0040, 1'b0, e0);
        exp_push(e0 + 1, "sdram_req_we",  snap(0, 1, 1, 2'b11, 1, 32'h0));
        exp_push(e0 + 2, "sdram_req_end", snap(0, 0, 0, 2'b11, 1, 32'h0));
        exp_push(e0 + 3, "sdram_dsack",   snap(0, 0, 0, 2'b01, 1, 32'h0));
        exp_push(e0 + 4, "sdram_release", snap(0, 0, 0, 2'b11, 1, 32'h0));
        wait_edge(e0 + 1); BRAM_ACK = 1'b1;
        wait_edge(e0 + 2); BRAM_ACK = 1'b0; SDRAM_ACK = 1'b1;
        wait_edge(e0 + 3); SDRAM_ACK = 1'b0; ASn = 1'b1;
        wait_edge(e0 + 4);

        // Unmapped read.
        start(32'h00AA_0000, 1'b1, e0);
        exp_push(e0 + 1, "unmapped_berr",    snap(0, 0, 0, 2'b11, 0, 32'h00AA_0000));
        exp_push(e0 + 3, "unmapped_release", snap(0, 0, 0, 2'b11, 1, 32'h00AA_0000));
        wait_edge(e0 + 2); ASn = 1'b1;
        wait_edge(e0 + 3);

        // Block RAM timeout (TIMEOUT_CYCLES=4): BERRn after edge 5.
        start(32'h0000_2000, 1'b1, e0);
        exp_push(e0 + 1, "to_sel",     snap(1, 0, 0, 2'b11, 1, 32'h00AA_0000));
        exp_push(e0 + 5, "to_berr",    snap(1, 0, 0, 2'b11, 0, 32'h0000_2000));
        exp_push(e0 + 6, "to_release", snap(0, 0, 0, 2'b11, 1, 32'h0000_2000));
        wait_edge(e0 + 5); ASn = 1'b1;
        wait_edge(e0 + 6);

        // Ack exactly at the timeout edge wins.
        start(32'h0000_3000, 1'b1, e0);
        exp_push(e0 + 1, "tie_sel",     snap(1, 0, 0, 2'b11, 1, 32'h0000_2000));
        exp_push(e0 + 5, "tie_dsack",   snap(1, 0, 0, 2'b00, 1, 32'h0000_2000));
        exp_push(e0 + 6, "tie_release", snap(0, 0, 0, 2'b11, 1, 32'h0000_2000));
        wait_edge(e0 + 4); BRAM_ACK = 1'b1;
        wait_edge(e0 + 5); BRAM_ACK = 1'b0; ASn = 1'b1;
        wait_edge(e0 + 6);

        // Abort in WAIT, then a late ack while idle.
        start(32'h0000_4000, 1'b1, e0);
        exp_push(e0 + 1, "abort_sel",  snap(1, 0, 0, 2'b11, 1, 32'h0000_2000));
        exp_push(e0 + 3, "abort_idle", snap(0, 0, 0, 2'b11, 1, 32'h0000_2000));
        wait_edge(e0 + 2); ASn = 1'b1;
        wait_edge(e0 + 3); BRAM_ACK = 1'b1;
        wait_edge(e0 + 5); BRAM_ACK = 1'b0;

        // Next cycle decodes normally; full timeout proves the counter was cleared.
        start(32'h0000_5000, 1'b1, e0);
        exp_push(e0 + 1, "post_abort_sel",  snap(1, 0, 0, 2'b11, 1, 32'h0000_2000));
        exp_push(e0 + 5, "post_abort_berr", snap(1, 0, 0, 2'b11, 0, 32'h0000_5000));
        wait_edge(e0 + 5);

        // Asynchronous reset pulse while in TERM, between clock edges.
        #1;
        exp_push(edge_no, "async_reset", snap(0, 0, 0, 2'b11, 1, 32'h0));
        reset_n = 1'b0;
        #1;
        ->ev_async;
        ASn = 1'b1;
        #1;
        reset_n = 1'b1;
        @(negedge clk);

        // SDRAM read with earliest ack: REQ ends and DSACKn appears after edge 2.
        start(32'h01FF_FFFC, 1'b1, e0);
        exp_push(e0 + 1, "sd_rd_req",     snap(0, 1, 0, 2'b11, 1, 32'h0));
        exp_push(e0 + 2, "sd_rd_dsack",   snap(0, 0, 0, 2'b01, 1, 32'h0));
        exp_push(e0 + 3, "sd_rd_release", snap(0, 0, 0, 2'b11, 1, 32'h0));
        wait_edge(e0 + 1); SDRAM_ACK = 1'b1;
        wait_edge(e0 + 2); SDRAM_ACK = 1'b0; ASn = 1'b1;
        wait_edge(e0 + 3);

        // First address above the block RAM region is unmapped.
        start(32'h0010_0000, 1'b1, e0);
        exp_push(e0 + 1, "bram_top_berr",    snap(0, 0, 0, 2'b11, 0, 32'h0010_0000));
        exp_push(e0 + 2, "bram_top_release", snap(0, 0, 0, 2'b11, 1, 32'h0010_0000));
        wait_edge(e0 + 1); ASn = 1'b1;
        wait_edge(e0 + 2);

        // Last block RAM word, earliest ack.
        start(32'h000F_FFFC, 1'b0, e0);
        exp_push(e0 + 1, "bram_last_sel",     snap(1, 0, 0, 2'b11, 1, 32'h0010_0000));
        exp_push(e0 + 2, "bram_last_dsack",   snap(1, 0, 0, 2'b00, 1, 32'h0010_0000));
        exp_push(e0 + 3, "bram_last_release", snap(0, 0, 0, 2'b11, 1, 32'h0010_0000));
        wait_edge(e0 + 1); BRAM_ACK = 1'b1;
        wait_edge(e0 + 2); BRAM_ACK = 1'b0; ASn = 1'b1;
        wait_edge(e0 + 3);

        repeat (3) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never observed, want %h @edge %0d", e.name, e.val, e.stamp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
